// File: rtl/instr_decoder_pkg.sv
// Shared instruction layout for the WRA program stream.
// Opcodes and field positions used by the decoder, DMA_WRA and the assembler.
package instr_decoder_pkg;

    localparam logic [3:0] OP_LAYER = 4'h1;
    localparam logic [3:0] OP_RDRES = 4'h2;
    localparam logic [3:0] OP_END   = 4'hF;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 28;
    localparam int TYPE_MSB  = 27;
    localparam int TYPE_LSB  = 24;
    localparam int INCH_MSB  = 23;
    localparam int INCH_LSB  = 16;
    localparam int OUTCH_MSB = 15;
    localparam int OUTCH_LSB = 8;
    localparam int MAP_MSB   = 7;
    localparam int MAP_LSB   = 0;
    localparam int RDLEN_MSB = 15;
    localparam int RDLEN_LSB = 0;

    typedef struct packed {
        logic [3:0] layer_type;
        logic [7:0] in_ch;
        logic [7:0] out_ch;
        logic [7:0] map_size;
    } layer_cfg_t;

    function automatic layer_cfg_t layer_fields(
        input logic [31:0] w
    );
        layer_cfg_t c;
        c.layer_type = w[TYPE_MSB:TYPE_LSB];
        c.in_ch      = w[INCH_MSB:INCH_LSB];
        c.out_ch     = w[OUTCH_MSB:OUTCH_LSB];
        c.map_size   = w[MAP_MSB:MAP_LSB];
        return c;
    endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Instr_Mem read port: address/enable from the decoder, data back
// from the synchronous memory one cycle later.
interface instr_decoder_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
);
    logic               instr_rd_en;
    logic [ADDR_W-1:0]  instr_addr;
    logic [INSTR_W-1:0] instr_rdata;

    modport master (
        output instr_rd_en,
        output instr_addr,
        input  instr_rdata
    );

    modport slave (
        input  instr_rd_en,
        input  instr_addr,
        output instr_rdata
    );
endinterface

// File: rtl/instr_decoder.sv
// Program counter, instruction register and config register bank
// for the WRA control FSM.
module instr_decoder
    import instr_decoder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ProgramCnt_en,
    input  logic           Cfg_en,
    instr_decoder_if.master mem,
    output logic           Model_done,
    output logic           ReadResult,
    output logic [3:0]     cfg_layer_type,
    output logic [7:0]     cfg_in_ch,
    output logic [7:0]     cfg_out_ch,
    output logic [7:0]     cfg_map_size,
    output logic [15:0]    cfg_rd_len,
    output logic [7:0]     layer_idx,
    output logic           decode_err
);

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_fresh;
    logic [INSTR_W-1:0] word;
    logic [3:0]         op;
    logic               is_layer;
    logic               is_rdres;
    logic               is_end;
    logic               illegal;
    logic               commit;
    layer_cfg_t         lf;

    // First decode cycle reads the memory port directly; ir holds it after.
    assign word = ir_fresh ? mem.instr_rdata : ir;
    assign op   = word[OP_MSB:OP_LSB];
    assign lf   = layer_fields(word[31:0]);

    assign is_layer = (op == OP_LAYER);
    assign is_rdres = (op == OP_RDRES);
    assign is_end   = (op == OP_END);
    assign illegal  = ~(is_layer | is_rdres | is_end);

    assign mem.instr_rd_en = ProgramCnt_en;
    assign mem.instr_addr  = pc;

    assign ReadResult = ir_valid & is_rdres;
    assign Model_done = ir_valid & (is_end | illegal);

    assign commit = Cfg_en & ir_valid & ~ProgramCnt_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= '0;
            ir             <= '0;
            ir_valid       <= 1'b0;
            ir_fresh       <= 1'b0;
            cfg_layer_type <= '0;
            cfg_in_ch      <= '0;
            cfg_out_ch     <= '0;
            cfg_map_size   <= '0;
            cfg_rd_len     <= '0;
            layer_idx      <= '0;
            decode_err     <= 1'b0;
        end else if (ProgramCnt_en) begin
            pc       <= pc + ADDR_W'(1);
            ir_valid <= 1'b1;
            ir_fresh <= 1'b1;
        end else begin
            if (ir_fresh) begin
                ir       <= mem.instr_rdata;
                ir_fresh <= 1'b0;
            end
            if (commit) begin
                ir_valid <= 1'b0;
                unique case (1'b1)
                    is_layer: begin
                        cfg_layer_type <= lf.layer_type;
                        cfg_in_ch      <= lf.in_ch;
                        cfg_out_ch     <= lf.out_ch;
                        cfg_map_size   <= lf.map_size;
                        if (layer_idx != 8'hFF)
                            layer_idx <= layer_idx + 8'd1;
                    end
                    is_rdres: begin
                        cfg_rd_len <= word[RDLEN_MSB:RDLEN_LSB];
                    end
                    default: begin
                        pc        <= '0;
                        layer_idx <= '0;
                        if (illegal)
                            decode_err <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
